fc_requant_argmax: RTL

FC_REQUANT_ARGMAX -- requirements
Module: fc_requant_argmax

---
 rtl/fc_requant_argmax.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fc_requant_argmax.sv
// FC output requantizer with output FIFO and running argmax.
// Define FC_ARGMAX_EN to build the argmax tracker; otherwise argmax outputs are 0.
module fc_requant_argmax #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int NUM_OUT    = 4096,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DATA_WIDTH-1:0]      ofm_in,
    input  logic                       valid_in,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_OUT)-1:0] argmax_idx,
    output logic [OUT_WIDTH-1:0]       argmax_val,
    output logic                       done,
    output logic                       overflow
);

    localparam int IW = $clog2(NUM_OUT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = (DATA_WIDTH + 1 > OUT_WIDTH + 1) ? DATA_WIDTH + 1 : OUT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic                   pv_q, pv_d;
    logic [OUT_WIDTH-1:0]   pq_q, pq_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [AW:0]            fcnt_q, fcnt_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];

    logic [EW-1:0]          sum_w;
    logic [EW-1:0]          sh_w;
    logic [OUT_WIDTH-1:0]   q_w;
    logic                   accept;
    logic                   pop;
    logic                   full;
    logic                   push;

    // Round-half-up shift; negative inputs clamp to zero, large ones saturate.
    always_comb begin
        sum_w = EW'(ofm_in) + EW'(1 << (SHIFT - 1));
        sh_w  = sum_w >> SHIFT;
        if (ofm_in[DATA_WIDTH-1]) begin
            q_w = '0;
        end else if (sh_w > EW'({OUT_WIDTH{1'b1}})) begin
            q_w = '1;
        end else begin
            q_w = sh_w[OUT_WIDTH-1:0];
        end
    end

    assign accept = (state_q == RUN) && valid_in && !start;
    assign pop    = (fcnt_q != '0) && out_ready;
    assign full   = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign push   = pv_q && (!full || pop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pv_d    = pv_q;
        pq_d    = pq_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fcnt_d  = fcnt_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            pv_d    = 1'b0;
            pq_d    = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            fcnt_d  = '0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            pv_d = accept;
            pq_d = q_w;
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            fcnt_d = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
            if (pv_q && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (accept) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IW'(NUM_OUT - 1)) begin
                    state_d = DRAIN;
                end
            end
            if (state_q == DRAIN && !pv_q && fcnt_q == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pv_q    <= 1'b0;
            pq_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pv_q    <= pv_d;
            pq_q    <= pq_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !start && push) begin
            mem_q[wptr_q] <= pq_q;
        end
    end

    assign out_valid = (fcnt_q != '0);
    assign out_data  = out_valid ? mem_q[rptr_q] : '0;
    assign done      = done_q;
    assign overflow  = ovf_q;

`ifdef FC_ARGMAX_EN
    logic [IW-1:0]        amax_idx_q, amax_idx_d;
    logic [OUT_WIDTH-1:0] amax_val_q, amax_val_d;

    // Strictly-greater update keeps the earliest index on ties.
    always_comb begin
        amax_idx_d = amax_idx_q;
        amax_val_d = amax_val_q;
        if (start) begin
            amax_idx_d = '0;
            amax_val_d = '0;
        end else if (accept && q_w > amax_val_q) begin
            amax_idx_d = cnt_q;
            amax_val_d = q_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            amax_idx_q <= '0;
            amax_val_q <= '0;
        end else begin
            amax_idx_q <= amax_idx_d;
            amax_val_q <= amax_val_d;
        end
    end

    assign argmax_idx = amax_idx_q;
    assign argmax_val = amax_val_q;
`else
    assign argmax_idx = '0;
    assign argmax_val = '0;
`endif

endmodule
